button_pio_debounced: RTL and testbench



---
 rtl/button_pio_debounced.sv | 143 ++++++++++++++
 tb/tb_button_pio_debounced.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/button_pio_debounced.sv
// Push-button PIO: Avalon-MM slave with WIDTH synchronised, optionally
// debounced button inputs, per-bit rise/fall edge capture (W1C), irq mask.
// Ports: clk, reset_n (async, active-low), address[2:0], chipselect,
//   write_n, writedata[31:0], in_port[WIDTH-1:0] -> readdata[31:0], irq.
// Optional feature macro: BUTTON_PIO_DEBOUNCE_EN (per-bit debounce filter).
module button_pio_debounced #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] db_d_q;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [31:0]      rdata_d, rdata_q;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rise, fall, set, clr;
    logic             wr;

    assign wdata = writedata[WIDTH-1:0];
    assign wr    = chipselect & ~write_n;

    generate
        if (WIDTH < 32) begin : g_wd_hi
            logic unused_wd_hi;
            assign unused_wd_hi = ^writedata[31:WIDTH];
        end
    endgenerate

    // Two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= IDLE_LEVEL;
            s2_q <= IDLE_LEVEL;
        end else begin
            s1_q <= in_port;
            s2_q <= s1_q;
        end
    end

`ifdef BUTTON_PIO_DEBOUNCE_EN
    localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0]    cnt_q [WIDTH];
    logic [WIDTH-1:0] db_q;

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive
    // cycles of disagreement; any agreement restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_q <= IDLE_LEVEL;
            for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (s2_q[i] == db_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    db_q[i]  <= s2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign db = db_q;
`else
    assign db = s2_q;
`endif

    assign rise = db & ~db_d_q;
    assign fall = ~db & db_d_q;
    assign set  = (rise & rise_en_q) | (fall & fall_en_q);

    always_comb begin
        mask_d    = mask_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr       = '0;
        if (wr) begin
            unique case (address)
                3'd2:    mask_d    = wdata;
                3'd3:    clr       = wdata;
                3'd4:    rise_en_d = wdata;
                3'd5:    fall_en_d = wdata;
                default: ;
            endcase
        end
        // Set has priority over W1C so a coincident event is kept.
        cap_d = (cap_q & ~clr) | set;
    end

    always_comb begin
        rdata_d = '0;
        unique case (address)
            3'd0:    rdata_d[WIDTH-1:0] = db;
            3'd1:    rdata_d[WIDTH-1:0] = s2_q;
            3'd2:    rdata_d[WIDTH-1:0] = mask_q;
            3'd3:    rdata_d[WIDTH-1:0] = cap_q;
            3'd4:    rdata_d[WIDTH-1:0] = rise_en_q;
            3'd5:    rdata_d[WIDTH-1:0] = fall_en_q;
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_d_q    <= IDLE_LEVEL;
            mask_q    <= '0;
            cap_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '1;
            rdata_q   <= '0;
        end else begin
            db_d_q    <= db;
            mask_q    <= mask_d;
            cap_q     <= cap_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            rdata_q   <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_button_pio_debounced.sv
// Directed self-checking bench for button_pio_debounced
// (WIDTH=4, DEBOUNCE_CYCLES=4, IDLE_LEVEL=4'hF).
module tb_button_pio_debounced;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int tests = 0;
    int fails = 0;

`ifdef BUTTON_PIO_DEBOUNCE_EN
    localparam int          LAT       = 7;
    localparam logic [31:0] PULSE_CAP = 32'h0;
`else
    localparam int          LAT       = 3;
    localparam logic [31:0] PULSE_CAP = 32'h2;
`endif

    button_pio_debounced #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(4),
        .IDLE_LEVEL(4'hF)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] v);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = v;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a,
                          input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(tag, d, exp);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;
        repeat (3) tick();
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        tick();

        // Reset register values
        rd_chk("rst_data", 3'd0, 32'hF);
        rd_chk("rst_raw", 3'd1, 32'hF);
        rd_chk("rst_mask", 3'd2, 32'h0);
        rd_chk("rst_cap", 3'd3, 32'h0);
        rd_chk("rst_rise", 3'd4, 32'h0);
        rd_chk("rst_fall", 3'd5, 32'hF);
        rd_chk("rd_addr6", 3'd6, 32'h0);
        rd_chk("rd_addr7", 3'd7, 32'h0);
        check("idle_irq", {31'b0, irq}, 32'h0);

        // Read-only writes ignored
        wr(3'd0, 32'h5);
        rd_chk("ro_data", 3'd0, 32'hF);

        // Press bit 0 with mask bit 0 enabled
        wr(3'd2, 32'h1);
        rd_chk("mask_rb", 3'd2, 32'h1);
        in_port = 4'hE;
        repeat (LAT - 1) tick();
        check("press_irq_early", {31'b0, irq}, 32'h0);
        tick();
        check("press_irq", {31'b0, irq}, 32'h1);
        rd_chk("press_data", 3'd0, 32'hE);
        rd_chk("press_raw", 3'd1, 32'hE);
        rd_chk("press_cap", 3'd3, 32'h1);
        wr(3'd3, 32'h1);
        check("w1c_irq", {31'b0, irq}, 32'h0);
        rd_chk("w1c_cap", 3'd3, 32'h0);

        // Release: rise not enabled, nothing captured
        in_port = 4'hF;
        repeat (10) tick();
        rd_chk("rel_cap", 3'd3, 32'h0);

        // 3-cycle glitch on bit 1
        in_port = 4'hD;
        repeat (3) tick();
        in_port = 4'hF;
        repeat (10) tick();
        rd_chk("glitch_data", 3'd0, 32'hF);
        rd_chk("glitch_cap", 3'd3, PULSE_CAP);
        wr(3'd3, 32'hF);
        rd_chk("glitch_clr", 3'd3, 32'h0);

        // Rise-only capture on bit 2
        wr(3'd4, 32'h4);
        wr(3'd5, 32'h0);
        in_port = 4'hB;
        repeat (12) tick();
        rd_chk("b2_press_data", 3'd0, 32'hB);
        rd_chk("b2_press_cap", 3'd3, 32'h0);
        in_port = 4'hF;
        repeat (12) tick();
        rd_chk("b2_rel_cap", 3'd3, 32'h4);
        check("b2_irq_masked", {31'b0, irq}, 32'h0);
        wr(3'd3, 32'hF);

        // Set vs. W1C collision on bit 0
        wr(3'd4, 32'h1);
        wr(3'd5, 32'h1);
        in_port = 4'hE;
        repeat (LAT + 2) tick();
        rd_chk("col_pre_cap", 3'd3, 32'h1);
        in_port = 4'hF;
        repeat (LAT - 1) tick();
        wr(3'd3, 32'h1);
        check("col_irq", {31'b0, irq}, 32'h1);
        rd_chk("col_cap", 3'd3, 32'h1);
        wr(3'd3, 32'h2);
        rd_chk("w1c_other", 3'd3, 32'h1);
        wr(3'd3, 32'h1);
        rd_chk("col_clr", 3'd3, 32'h0);

        // Reset during a debounce count
        in_port = 4'hE;
        repeat (4) tick();
        reset_n = 1'b0;
        in_port = 4'hF;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (10) tick();
        rd_chk("mrst_cap", 3'd3, 32'h0);
        rd_chk("mrst_data", 3'd0, 32'hF);
        rd_chk("mrst_fall", 3'd5, 32'hF);
        check("mrst_irq", {31'b0, irq}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
